// File: rtl/bcd_converter_pkg.sv
// Shared display package: BCD digit sizing used by the converter and the streamer.
package bcd_converter_pkg;

    localparam int DIGITS_NUM_DEF = 6;
    localparam int BCD_W          = 4;

    function automatic longint unsigned max_value(input int digits);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bcd_converter_if.sv
// Request/result handshake between a binary source, the converter and the display streamer.
interface bcd_converter_if
    import bcd_converter_pkg::*;
#(
    parameter int DIGITS_NUM = DIGITS_NUM_DEF,
    parameter int BIN_WIDTH  = 20
);

    logic [BIN_WIDTH-1:0]        value;
    logic                        value_stb;
    logic                        ready;
    logic [BCD_W*DIGITS_NUM-1:0] digits;
    logic                        overflow;
    logic                        digits_stb;
    logic                        digits_ready;

    modport master (
        output value, value_stb, digits_ready,
        input  ready, digits, overflow, digits_stb
    );

    modport slave (
        input  value, value_stb, digits_ready,
        output ready, digits, overflow, digits_stb
    );

endinterface

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_add3_nibble (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/bcd_converter.sv
// Iterative binary-to-BCD converter (double-dabble), one input bit per clock.
module bcd_converter
    import bcd_converter_pkg::*;
#(
    parameter int DIGITS_NUM = DIGITS_NUM_DEF,
    parameter int BIN_WIDTH  = 20
) (
    input logic            clk_in,
    input logic            reset_in,
    bcd_converter_if.slave bus
);

    localparam int ACC_W = BCD_W * DIGITS_NUM;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_WIDTH - 1);
    localparam logic [63:0] MAX_VAL = max_value(DIGITS_NUM);

    typedef enum logic [1:0] {
        S_RESET,
        S_IDLE,
        S_CONVERT,
        S_OUTPUT
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     adj;
    logic [ACC_W-1:0]     shifted;
    logic [BIN_WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 flag_q, flag_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_W-1:0]     dig_q, dig_d;

    for (genvar i = 0; i < DIGITS_NUM; i++) begin : g_dig
        bcd_add3_nibble u_add3 (
            .nib_i(acc_q[i*BCD_W +: BCD_W]),
            .nib_o(adj[i*BCD_W +: BCD_W])
        );
    end

    // Carry out of the top nibble is dropped; only overflowed inputs reach it.
    assign shifted = {adj[ACC_W-2:0], sh_q[BIN_WIDTH-1]};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        unique case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (bus.value_stb) begin
                    state_d = S_CONVERT;
                    sh_d    = bus.value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    flag_d  = 64'(bus.value) > MAX_VAL;
                end
            end
            S_CONVERT: begin
                acc_d = shifted;
                sh_d  = {sh_q[BIN_WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = S_OUTPUT;
                    dig_d   = flag_q ? {DIGITS_NUM{4'h9}} : shifted;
                    ovf_d   = flag_q;
                end
            end
            S_OUTPUT: begin
                if (bus.digits_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= S_RESET;
            acc_q   <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
        end
    end

    assign bus.ready      = (state_q == S_IDLE);
    assign bus.digits     = dig_q;
    assign bus.overflow   = ovf_q;
    assign bus.digits_stb = (state_q == S_OUTPUT) && bus.digits_ready;

endmodule

// File: tb/tb_bcd_converter.sv
// Randomized and directed checks of bcd_converter against a decimal reference model.
module tb_bcd_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bcd_converter_if #(.DIGITS_NUM(6), .BIN_WIDTH(20)) bus ();

    bcd_converter #(.DIGITS_NUM(6), .BIN_WIDTH(20)) dut (
        .clk_in  (clk),
        .reset_in(rst),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        if (v > 999999) return 24'h999999;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Accept v, optionally pulse a stray request mid-conversion, wait for strobe.
    task automatic convert(input int unsigned v, input bit stray);
        int n;
        logic [23:0] exp;
        exp = model_bcd(v);
        @(negedge clk);
        check("ready_before", 32'(bus.ready), 32'd1);
        bus.value     = 20'(v);
        bus.value_stb = 1'b1;
        @(negedge clk);
        bus.value_stb = 1'b0;
        n = 1;
        while (!bus.digits_stb && n < 100) begin
            if (stray && n == 5) begin
                bus.value     = 20'd7;
                bus.value_stb = 1'b1;
            end else begin
                bus.value_stb = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        bus.value_stb = 1'b0;
        check("latency", 32'(n), 32'd21);
        check("digits", 32'(bus.digits), 32'(exp));
        check("overflow", 32'(bus.overflow), 32'(v > 999999));
        @(negedge clk);
        check("stb_one_cycle", 32'(bus.digits_stb), 32'd0);
        check("ready_after", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        int unsigned v;
        bit stb_seen;
        bit dig_moved;
        logic [23:0] held;

        bus.value        = '0;
        bus.value_stb    = 1'b0;
        bus.digits_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_stb", 32'(bus.digits_stb), 32'd0);
        check("rst_digits", 32'(bus.digits), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        #1 check("post_rst_ready", 32'(bus.ready), 32'd0);

        convert(123456, 1'b0);
        convert(0, 1'b0);
        convert(999999, 1'b0);
        convert(1000000, 1'b0);
        convert(20'hFFFFF, 1'b0);
        convert(1, 1'b0);

        for (int k = 0; k < 20; k++) begin
            if (k % 4 == 3) v = $urandom_range(0, 20'hFFFFF);
            else v = $urandom_range(0, 999999);
            convert(v, 1'b0);
        end

        convert(654321, 1'b1);

        // Backpressure: hold result for 50 cycles with downstream not ready.
        bus.digits_ready = 1'b0;
        @(negedge clk);
        bus.value     = 20'd4321;
        bus.value_stb = 1'b1;
        @(negedge clk);
        bus.value_stb = 1'b0;
        repeat (20) @(negedge clk);
        held = model_bcd(4321);
        stb_seen  = 1'b0;
        dig_moved = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.digits_stb) stb_seen = 1'b1;
            if (bus.digits !== held) dig_moved = 1'b1;
            @(negedge clk);
        end
        check("bp_no_stb", 32'(stb_seen), 32'd0);
        check("bp_digits_stable", 32'(dig_moved), 32'd0);
        check("bp_not_ready", 32'(bus.ready), 32'd0);
        bus.digits_ready = 1'b1;
        #1 check("bp_stb", 32'(bus.digits_stb), 32'd1);
        check("bp_digits", 32'(bus.digits), 32'(held));
        @(negedge clk);
        check("bp_stb_drop", 32'(bus.digits_stb), 32'd0);
        check("bp_ready", 32'(bus.ready), 32'd1);

        // Reset at conversion cycle 10 aborts without a strobe.
        bus.value     = 20'd555555;
        bus.value_stb = 1'b1;
        @(negedge clk);
        bus.value_stb = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        stb_seen = 1'b0;
        #1 check("abort_ready_low", 32'(bus.ready), 32'd0);
        check("abort_digits", 32'(bus.digits), 32'd0);
        @(negedge clk);
        check("abort_ready_high", 32'(bus.ready), 32'd1);
        for (int c = 0; c < 30; c++) begin
            if (bus.digits_stb) stb_seen = 1'b1;
            @(negedge clk);
        end
        check("abort_no_stb", 32'(stb_seen), 32'd0);

        convert(987654, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
